// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream handshake between host link and imem_loader
interface imem_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream writer into instruction memory, holds core until loaded
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int MEM_NBYTE = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    imem_loader_if.slave      link,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;
    localparam state_t FIN = CSUM;
`else
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
    localparam state_t FIN = DONE;
`endif

    localparam logic [15:0] MAX_LEN = 16'(MEM_NBYTE);

    state_t      state, state_nx;
    logic        s_ready_q, xfer;
    logic [15:0] len, cnt, len_full;
    logic        s_ready_nx, mem_we_nx, busy_nx, done_nx, error_nx, cpu_hold_nx;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum, csum_tot;
    assign csum_tot = sum + link.s_data;
`endif

    // start outranks a coincident byte, which is left on the link
    assign xfer         = link.s_valid && s_ready_q && !start;
    assign len_full     = {link.s_data, len[7:0]};
    assign link.s_ready = s_ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_ready_q <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_hold  <= 1'b1;
            len       <= 16'd0;
            cnt       <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum       <= 8'd0;
`endif
        end else begin
            state     <= state_nx;
            s_ready_q <= s_ready_nx;
            mem_we    <= mem_we_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            error     <= error_nx;
            cpu_hold  <= cpu_hold_nx;
            if (mem_we_nx) begin
                mem_waddr <= cnt[ADDR_W-1:0];
                mem_wdata <= link.s_data;
            end
            if (start) begin
                len <= 16'd0;
                cnt <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum <= 8'd0;
`endif
            end else if (xfer) begin
                case (state)
                    LEN_LO: len[7:0]  <= link.s_data;
                    LEN_HI: len[15:8] <= link.s_data;
                    DATA: begin
                        cnt <= cnt + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum <= sum + link.s_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = LEN_LO;
        end else if (xfer) begin
            case (state)
                LEN_LO: state_nx = LEN_HI;
                LEN_HI: begin
                    if (len_full > MAX_LEN)
                        state_nx = ERR;
                    else if (len_full == 16'd0)
                        state_nx = FIN;
                    else
                        state_nx = DATA;
                end
                DATA: if (cnt == len - 16'd1) state_nx = FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: state_nx = (csum_tot == 8'd0) ? DONE : ERR;
`endif
                default: ;
            endcase
        end
    end

    // Outputs are registered copies of the decode of the next state
    always_comb begin
        busy_nx     = (state_nx != IDLE) && (state_nx != DONE) && (state_nx != ERR);
        s_ready_nx  = busy_nx && !start;
        mem_we_nx   = xfer && (state == DATA);
        done_nx     = (state_nx == DONE);
        error_nx    = (state_nx == ERR);
        cpu_hold_nx = (state_nx != DONE);
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Sequential writer for the byte-addressed instruction memory (4096 B default).
- Consumes a framed byte stream over a valid/ready handshake: 2-byte little-endian length, then payload.
- Drives a 1-byte-per-cycle write port (address 0 upward) into instruction memory.
- Holds the core in reset (cpu_hold) until a load completes successfully. Sits between the host/debug byte link and the IMEM write side.

Parameters:
- MEM_NBYTE, 4096, instruction memory size in bytes; maximum accepted payload length.
- ADDR_W, 12, width of mem_waddr; must satisfy 2^ADDR_W >= MEM_NBYTE.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse; begins a new load frame
- s_data  input  8  stream byte
- s_valid  input  1  s_data valid
- s_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  byte write strobe to instruction memory
- mem_waddr  output  ADDR_W  byte write address
- mem_wdata  output  8  byte write data
- busy  output  1  frame in progress
- done  output  1  sticky: last frame loaded successfully
- error  output  1  sticky: last frame rejected
- cpu_hold  output  1  hold core in reset while high

Behaviour:
- Reset is synchronous, active-low; one clock; no other clock domains.
- Reset values: state IDLE; s_ready, mem_we, busy, done, error = 0; mem_waddr, mem_wdata = 0; cpu_hold = 1; length and byte counters = 0.
- Transfer rule: a byte transfers on a rising edge where s_valid && s_ready. s_ready is a registered state decode: 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 otherwise.
- s_data is ignored whenever no transfer occurs.
- States and transitions:
  - IDLE: on start -> LEN_LO; clear done, error and counters; busy = 1; cpu_hold = 1.
  - LEN_LO: on transfer, latch len[7:0] -> LEN_HI.
  - LEN_HI: on transfer, latch len[15:8], then:
    - len > MEM_NBYTE -> ERR.
    - len == 0 -> DONE (or CSUM when the feature is enabled).
    - otherwise -> DATA.
  - DATA: on each transfer, write the byte at address cnt; cnt increments.
    - After transfer number len (cnt == len-1 at accept) -> DONE (or CSUM).
    - cnt never wraps, because len <= MEM_NBYTE.
  - DONE: busy = 0, done = 1, cpu_hold = 0. A start pulse begins a new frame and raises cpu_hold again.
  - ERR: busy = 0, error = 1, cpu_hold = 1. A start pulse begins a new frame.
- Write latency: the accepted byte appears on mem_we/mem_waddr/mem_wdata exactly 1 cycle after the accepting edge (registered outputs).
- mem_we is high for exactly one cycle per payload byte. mem_we = 0 in all other cycles, including the cycle after a header byte.
- Throughput: with s_valid held high, one byte per cycle; no bubbles between header and payload.
- start while busy: aborts the current frame and restarts at LEN_LO. Counters clear; bytes already written stay in memory; no mem_we in the restart cycle.
- start simultaneous with a transfer: start wins, and the byte is not consumed. s_ready is 0 in the cycle after start is sampled.
- Reset mid-frame: returns to IDLE with the reset values above; any in-flight write strobe is dropped.
- cpu_hold rises in the same cycle busy rises and falls only on the edge entering DONE.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - A running 8-bit sum (mod 256) of the payload bytes is kept.
  - After the last payload byte (or after LEN_HI when len == 0), the FSM goes to CSUM and accepts one more byte.
  - If (sum + byte) mod 256 == 0 -> DONE; otherwise -> ERR.
  - The checksum byte is never written to memory.
- When undefined: no CSUM state and no accumulator; DATA (or LEN_HI when len == 0) goes directly to DONE.

Test Plan:
- Basic load: start, then stream 0x08 0x00 plus 8 bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x50,0x00 with valid held high -> 8 mem_we pulses at addresses 0..7 with matching data, 1 cycle after each accept; done = 1, cpu_hold = 0, busy = 0.
- Backpressure/gaps: same frame with s_valid toggled every other cycle -> identical write sequence, no duplicate or missing writes, s_ready stays 1 throughout DATA.
- Oversize length: header 0x01 0x10 (4097) -> no mem_we, error = 1, cpu_hold = 1; a following valid start and frame loads successfully and clears error.
- Zero length: header 0x00 0x00 -> done = 1 (checksum byte 0x00 required when enabled), no writes.
- Abort/reset: start, 4 payload bytes of an 8-byte frame, then start pulse -> FSM back in LEN_LO, mem_we = 0; repeat with rst_n = 0 mid-frame -> all outputs return to reset values, cpu_hold = 1.
- Checksum (macro defined): payload 0x01,0x02,0x03 + 0xFA -> done; same payload + 0xFB -> error, cpu_hold stays 1.
